// File: rtl/multicycle_main_control.sv
// multicycle_main_control: multi-cycle main control FSM driving ALUOp, datapath strobes and a retire counter.
// Define ILLEGAL_TRAP_EN to trap illegal opcodes in TRAP; otherwise they retire as NOPs.
module multicycle_main_control #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [3:0]       i_opcode,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic [1:0]       o_aluop,
  output logic             o_iord,
  output logic             o_irwrite,
  output logic             o_memread,
  output logic             o_memwrite,
  output logic             o_regwrite,
  output logic             o_regdst,
  output logic             o_memtoreg,
  output logic             o_alusrca,
  output logic [1:0]       o_alusrcb,
  output logic [1:0]       o_pcsource,
  output logic             o_pcwrite,
  output logic             o_pcwritecond,
  output logic             o_pc_en,
  output logic [3:0]       o_state,
  output logic [CNT_W-1:0] o_retired_cnt,
  output logic             o_illegal
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADDR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, REX = 4'd6, RWB = 4'd7, IEX = 4'd8, IWB = 4'd9,
    BRANCH = 4'd10, JUMP = 4'd11, TRAP = 4'd12
  } state_t;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  state_t           r_state, w_next;
  logic [3:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             w_is_r, w_is_i, w_is_mem, w_legal, w_retire;
  assign w_is_r   = i_opcode[3:2] == 2'b00 && i_opcode[1:0] != 2'b11;
  assign w_is_i   = i_opcode inside {4'h9, 4'hA, 4'hB};
  assign w_is_mem = i_opcode[3:1] == 3'b110;
  assign w_legal  = w_is_r || w_is_i || w_is_mem || i_opcode[3:1] == 3'b111;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= FETCH;
      r_op    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) r_op <= i_opcode;
      if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
  always_comb begin
    w_next        = r_state;
    w_retire      = 1'b0;
    o_aluop       = 2'b00;
    o_iord        = 1'b0;
    o_irwrite     = 1'b0;
    o_memread     = 1'b0;
    o_memwrite    = 1'b0;
    o_regwrite    = 1'b0;
    o_regdst      = 1'b0;
    o_memtoreg    = 1'b0;
    o_alusrca     = 1'b0;
    o_alusrcb     = 2'b00;
    o_pcsource    = 2'b00;
    o_pcwrite     = 1'b0;
    o_pcwritecond = 1'b0;
    case (r_state)
      FETCH: begin
        o_memread = 1'b1;
        o_alusrcb = 2'b01;
        o_irwrite = i_mem_ready;
        o_pcwrite = i_mem_ready;
        w_next    = i_mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        o_alusrcb = 2'b11;
        w_retire  = !w_legal && !TRAP_EN;
        w_next    = w_is_mem ? MEMADDR : w_is_r ? REX : w_is_i ? IEX :
                    i_opcode == 4'hE ? BRANCH : i_opcode == 4'hF ? JUMP :
                    TRAP_EN ? TRAP : FETCH;
      end
      MEMADDR: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
        w_next    = r_op[0] ? MEMWR : MEMRD;
      end
      MEMRD: begin
        o_memread = 1'b1;
        o_iord    = 1'b1;
        w_next    = i_mem_ready ? MEMWB : MEMRD;
      end
      MEMWR: begin
        o_memwrite = 1'b1;
        o_iord     = 1'b1;
        w_retire   = i_mem_ready;
        w_next     = i_mem_ready ? FETCH : MEMWR;
      end
      MEMWB: begin
        o_regwrite = 1'b1;
        o_memtoreg = 1'b1;
        w_retire   = 1'b1;
        w_next     = FETCH;
      end
      REX: begin
        o_alusrca = 1'b1;
        o_aluop   = 2'b10;
        w_next    = RWB;
      end
      RWB: begin
        o_regwrite = 1'b1;
        o_regdst   = 1'b1;
        w_retire   = 1'b1;
        w_next     = FETCH;
      end
      IEX: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
        o_aluop   = 2'b11;
        w_next    = IWB;
      end
      IWB: begin
        o_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = FETCH;
      end
      BRANCH: begin
        o_alusrca     = 1'b1;
        o_aluop       = 2'b01;
        o_pcwritecond = 1'b1;
        o_pcsource    = 2'b01;
        w_retire      = 1'b1;
        w_next        = FETCH;
      end
      JUMP: begin
        o_pcwrite  = 1'b1;
        o_pcsource = 2'b10;
        w_retire   = 1'b1;
        w_next     = FETCH;
      end
      TRAP:    w_next = TRAP;
      default: w_next = FETCH;
    endcase
  end
  assign o_pc_en       = o_pcwrite || (o_pcwritecond && i_zero);
  assign o_state       = r_state;
  assign o_retired_cnt = r_cnt;
  assign o_illegal     = TRAP_EN && r_state == TRAP;
endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control: table-driven per-cycle check of states, control strobes and retire count,
// plus hand sequences for illegal opcodes, async reset mid-MEMRD and counter wrap (CNT_W=4).
module tb_multicycle_main_control;
  localparam int W = 4;
  // ctrl = {iord, irwrite, memread, memwrite, regwrite, regdst, memtoreg, alusrca, alusrcb, pcsource, pcwrite, pcwritecond, pc_en, aluop}
  localparam logic [16:0] C_F0  = 17'b0_0_1_0_0_0_0_0_01_00_0_0_0_00;
  localparam logic [16:0] C_FR  = 17'b0_1_1_0_0_0_0_0_01_00_1_0_1_00;
  localparam logic [16:0] C_DEC = 17'b0_0_0_0_0_0_0_0_11_00_0_0_0_00;
  localparam logic [16:0] C_MA  = 17'b0_0_0_0_0_0_0_1_10_00_0_0_0_00;
  localparam logic [16:0] C_MR  = 17'b1_0_1_0_0_0_0_0_00_00_0_0_0_00;
  localparam logic [16:0] C_MW  = 17'b1_0_0_1_0_0_0_0_00_00_0_0_0_00;
  localparam logic [16:0] C_MWB = 17'b0_0_0_0_1_0_1_0_00_00_0_0_0_00;
  localparam logic [16:0] C_REX = 17'b0_0_0_0_0_0_0_1_00_00_0_0_0_10;
  localparam logic [16:0] C_RWB = 17'b0_0_0_0_1_1_0_0_00_00_0_0_0_00;
  localparam logic [16:0] C_IEX = 17'b0_0_0_0_0_0_0_1_10_00_0_0_0_11;
  localparam logic [16:0] C_IWB = 17'b0_0_0_0_1_0_0_0_00_00_0_0_0_00;
  localparam logic [16:0] C_BR1 = 17'b0_0_0_0_0_0_0_1_00_01_0_1_1_01;
  localparam logic [16:0] C_BR0 = 17'b0_0_0_0_0_0_0_1_00_01_0_1_0_01;
  localparam logic [16:0] C_J   = 17'b0_0_0_0_0_0_0_0_00_10_1_0_1_00;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic [1:0] aluop, alusrcb, pcsource;
  logic iord, irwrite, memread, memwrite, regwrite, regdst, memtoreg, alusrca;
  logic pcwrite, pcwritecond, pc_en, illegal;
  logic [3:0] state;
  logic [W-1:0] cnt;
  logic [16:0] ctrl;
  int n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  multicycle_main_control #(.CNT_W(W)) dut (
    .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_zero(zero), .i_mem_ready(mem_ready),
    .o_aluop(aluop), .o_iord(iord), .o_irwrite(irwrite), .o_memread(memread),
    .o_memwrite(memwrite), .o_regwrite(regwrite), .o_regdst(regdst), .o_memtoreg(memtoreg),
    .o_alusrca(alusrca), .o_alusrcb(alusrcb), .o_pcsource(pcsource), .o_pcwrite(pcwrite),
    .o_pcwritecond(pcwritecond), .o_pc_en(pc_en), .o_state(state), .o_retired_cnt(cnt),
    .o_illegal(illegal)
  );
  assign ctrl = {iord, irwrite, memread, memwrite, regwrite, regdst, memtoreg, alusrca,
                 alusrcb, pcsource, pcwrite, pcwritecond, pc_en, aluop};
  typedef struct {
    logic [3:0]  op;
    logic        rdy;
    logic        z;
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic [3:0]  cnt;
  } vec_t;
  vec_t v[$];
  function automatic vec_t mk(input logic [3:0] op, input logic rdy, input logic z,
                              input logic [3:0] st, input logic [16:0] c, input logic [3:0] n);
    vec_t r;
    r.op = op; r.rdy = rdy; r.z = z; r.st = st; r.ctrl = c; r.cnt = n;
    return r;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step(input logic [3:0] o, input logic r, input logic zz);
    @(negedge clk);
    opcode = o; mem_ready = r; zero = zz;
    #1;
  endtask
  task automatic chk_core(input string nm, input logic [3:0] st, input logic [16:0] c, input logic [3:0] n);
    chk({nm, ".state"}, 32'(state), 32'(st));
    chk({nm, ".ctrl"}, 32'(ctrl), 32'(c));
    chk({nm, ".cnt"}, 32'(cnt), 32'(n));
  endtask
  initial begin
    // R-type arith
    v.push_back(mk(4'h1, 1, 0, 0, C_FR, 0));  v.push_back(mk(4'h1, 1, 0, 1, C_DEC, 0));
    v.push_back(mk(4'hF, 1, 0, 6, C_REX, 0)); v.push_back(mk(4'hF, 1, 0, 7, C_RWB, 0));
    // addi
    v.push_back(mk(4'h9, 1, 0, 0, C_FR, 1));  v.push_back(mk(4'h9, 1, 0, 1, C_DEC, 1));
    v.push_back(mk(4'h9, 1, 0, 8, C_IEX, 1)); v.push_back(mk(4'h9, 1, 0, 9, C_IWB, 1));
    // lw with one fetch wait and two MEMRD waits; opcode flipped to sw after DECODE
    v.push_back(mk(4'hC, 0, 0, 0, C_F0, 2));  v.push_back(mk(4'hC, 1, 0, 0, C_FR, 2));
    v.push_back(mk(4'hC, 1, 0, 1, C_DEC, 2)); v.push_back(mk(4'hD, 1, 0, 2, C_MA, 2));
    v.push_back(mk(4'hC, 0, 0, 3, C_MR, 2));  v.push_back(mk(4'hC, 0, 0, 3, C_MR, 2));
    v.push_back(mk(4'hC, 1, 0, 3, C_MR, 2));  v.push_back(mk(4'hC, 1, 0, 4, C_MWB, 2));
    // sw with one MEMWR wait; opcode flipped to lw after DECODE
    v.push_back(mk(4'hD, 1, 0, 0, C_FR, 3));  v.push_back(mk(4'hD, 1, 0, 1, C_DEC, 3));
    v.push_back(mk(4'hC, 1, 0, 2, C_MA, 3));  v.push_back(mk(4'hD, 0, 0, 5, C_MW, 3));
    v.push_back(mk(4'hD, 1, 0, 5, C_MW, 3));
    // beq taken then not taken
    v.push_back(mk(4'hE, 1, 1, 0, C_FR, 4));  v.push_back(mk(4'hE, 1, 1, 1, C_DEC, 4));
    v.push_back(mk(4'hE, 1, 1, 10, C_BR1, 4));
    v.push_back(mk(4'hE, 1, 0, 0, C_FR, 5));  v.push_back(mk(4'hE, 1, 0, 1, C_DEC, 5));
    v.push_back(mk(4'hE, 1, 0, 10, C_BR0, 5));
    // j
    v.push_back(mk(4'hF, 1, 0, 0, C_FR, 6));  v.push_back(mk(4'hF, 1, 0, 1, C_DEC, 6));
    v.push_back(mk(4'h0, 1, 0, 11, C_J, 6));
    repeat (2) @(negedge clk);
    #1;
    chk_core("reset", 4'd0, C_F0, 4'd0);
    chk("reset.illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    foreach (v[i]) begin
      step(v[i].op, v[i].rdy, v[i].z);
      chk_core($sformatf("vec%0d", i), v[i].st, v[i].ctrl, v[i].cnt);
      chk($sformatf("vec%0d.illegal", i), 32'(illegal), 32'd0);
    end
    // illegal opcode 0101
    step(4'h5, 1, 0); chk_core("ill.fetch", 4'd0, C_FR, 4'd7);
    step(4'h5, 1, 0); chk_core("ill.decode", 4'd1, C_DEC, 4'd7);
`ifdef ILLEGAL_TRAP_EN
    for (int k = 0; k < 4; k++) begin
      step(4'h1, 1, 1);
      chk_core($sformatf("trap%0d", k), 4'd12, 17'd0, 4'd7);
      chk($sformatf("trap%0d.illegal", k), 32'(illegal), 32'd1);
    end
`else
    step(4'h1, 0, 0); chk_core("ill.nop", 4'd0, C_F0, 4'd8);
    chk("ill.nop.illegal", 32'(illegal), 32'd0);
`endif
    step(4'hC, 0, 0);
    reset = 1'b1;
    #1;
    chk_core("reset2", 4'd0, C_F0, 4'd0);
    chk("reset2.illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    // async reset in the middle of MEMRD
    step(4'hC, 1, 0); step(4'hC, 1, 0); step(4'hC, 1, 0);
    step(4'hC, 0, 0); chk("memrd.state", 32'(state), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk_core("async", 4'd0, C_F0, 4'd0);
    chk("async.strobes", 32'({memwrite, regwrite}), 32'd0);
    @(posedge clk);
    #1 chk_core("async.hold", 4'd0, C_F0, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk_core("async.release", 4'd0, C_F0, 4'd0);
    // wrap: 15 jumps reach 2^W-1, one more returns to 0
    for (int k = 0; k < 15; k++) begin
      step(4'hF, 1, 0); step(4'hF, 1, 0); step(4'hF, 1, 0);
    end
    step(4'hF, 0, 0); chk_core("wrap.max", 4'd0, C_F0, 4'd15);
    step(4'hF, 1, 0); step(4'hF, 1, 0); step(4'hF, 1, 0);
    step(4'hF, 0, 0); chk_core("wrap.zero", 4'd0, C_F0, 4'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
